// File: rtl/seg7_monitor.sv
// seg7_monitor: receive-side checker for a 7-segment digit bus.
// Samples the segment pattern, debounces it with a stability window,
// decodes stable patterns to BCD, checks for a mod-10 up-count and
// measures the cycle count between accepted digits.
module seg7_monitor #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned CNT_WIDTH     = 24
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [6:0]           segments,
    output logic [3:0]           digit,
    output logic                 digit_valid,
    output logic                 seq_error,
    output logic                 bad_pattern,
    output logic                 locked,
    output logic [CNT_WIDTH-1:0] period
);

    localparam logic [7:0] STAB_MAX = 8'(STABLE_CYCLES);

    typedef enum logic {
        ST_IDLE,
        ST_LOCKED
    } state_t;

    state_t               state;
    logic [6:0]           samp;
    logic [7:0]           stab;
    logic [6:0]           last_acc;
    logic                 has_acc;
    logic [CNT_WIDTH-1:0] pcnt;
    logic [3:0]           dec;
    logic                 dec_ok;
    logic                 accept;
    logic [3:0]           next_digit;

    // Register the raw pattern and count consecutive identical samples
    always_ff @(posedge clk) begin
        if (reset) begin
            samp <= '0;
            stab <= '0;
        end else begin
            samp <= segments;
            if (segments != samp) begin
                stab <= 8'd1;
            end else if (stab != STAB_MAX) begin
                stab <= stab + 8'd1;
            end
        end
    end

    // Decode the stable sample back to a BCD digit (bit6..bit0 = g..a)
    always_comb begin
        dec    = '0;
        dec_ok = 1'b1;
        case (samp)
            7'b0111111: dec = 4'd0;
            7'b0000110: dec = 4'd1;
            7'b1011011: dec = 4'd2;
            7'b1001111: dec = 4'd3;
            7'b1100110: dec = 4'd4;
            7'b1101101: dec = 4'd5;
            7'b1111100: dec = 4'd6;
            7'b0000111: dec = 4'd7;
            7'b1111111: dec = 4'd8;
            7'b1100111: dec = 4'd9;
            default:    dec_ok = 1'b0;
        endcase
    end

    // A stable sample is taken once, and never again while it repeats
    always_comb begin
        accept     = (stab == STAB_MAX) && (!has_acc || (samp != last_acc));
        next_digit = (digit == 4'd9) ? 4'd0 : 4'(digit + 4'd1);
    end

    // Remember the last accepted pattern so it is not re-accepted
    always_ff @(posedge clk) begin
        if (reset) begin
            last_acc <= '0;
            has_acc  <= 1'b0;
        end else if (accept) begin
            last_acc <= samp;
            has_acc  <= 1'b1;
        end
    end

    // Tracking FSM with registered pulses, digit, period and period counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            locked      <= 1'b0;
            digit       <= '0;
            digit_valid <= 1'b0;
            seq_error   <= 1'b0;
            bad_pattern <= 1'b0;
            period      <= '0;
            pcnt        <= '0;
        end else begin
            digit_valid <= 1'b0;
            seq_error   <= 1'b0;
            bad_pattern <= 1'b0;
            if (pcnt != '1) begin
                pcnt <= pcnt + CNT_WIDTH'(1);
            end
            if (accept) begin
                if (dec_ok) begin
                    digit       <= dec;
                    digit_valid <= 1'b1;
                    // Count restarts at 1 so the next period spans acceptance edges
                    pcnt        <= CNT_WIDTH'(1);
                    if (state == ST_LOCKED) begin
                        seq_error <= (dec != next_digit);
                        period    <= pcnt;
                    end else begin
                        period    <= '0;
                    end
                    state  <= ST_LOCKED;
                    locked <= 1'b1;
                end else begin
                    bad_pattern <= 1'b1;
                    state       <= ST_IDLE;
                    locked      <= 1'b0;
                end
            end
        end
    end

endmodule
